mcu_bus_if: RTL and testbench
=============================

Name: mcu_bus_if

Overview:
- Microcontroller bus interface sitting directly upstream of the TH99CHLS core.
- Decodes the multiplexed MCU bus: high address on ABUS, low address then data on DBUS, with CSbar/ALE/Rbar/Wbar strobes.
- Holds the 10-entry configuration register file: B0..B6, operand, hour, minute.
- Presents the registers as plain registered outputs to the core; optionally supports MCU readback.

Parameters:
- SYNC_STAGES, 2, flops per synchroniser on every asynchronous bus input (min 2).
- BASE_ADDR, 16'h0000, 16-bit address of B0; the map is BASE_ADDR+0 .. BASE_ADDR+9.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-low reset
- abus  in  8  address high byte
- dbus_in  in  8  DBUS input (address low byte, then data)
- dbus_out  out  8  readback data
- dbus_oe  out  1  DBUS drive enable; the top level builds the tristate
- csbar, ale, rbar, wbar  in  1 each  MCU strobes, asynchronous
- b_regs  out  56  B0..B6, with B0 in [7:0]
- operand, hour, minute  out  8 each  configuration registers
- wr_pulse  out  1  one-cycle pulse on each committed write
- wr_index  out  4  register index of the last committed write
- range_err  out  1  sticky flag: rejected hour/minute value
- proto_err  out  1  sticky flag: Rbar and Wbar low together
- err_clr  in  1  synchronous clear of both sticky flags

Behaviour:
- Reset (reset==0 at a clock edge):
  - All register outputs, wr_index, dbus_out, range_err and proto_err go to 0; wr_pulse and dbus_oe go to 0.
  - FSM goes to IDLE. Synchronisers are reset to inactive levels: strobes high, ALE low.
  - Reset mid-transaction aborts it with no commit.
- Input synchronisation:
  - abus, dbus_in, csbar, ale, rbar and wbar pass through SYNC_STAGES flops.
  - Edge detection runs on the synchronised values; data stays aligned with the strobes.
- FSM states: IDLE, SEL, ADDR, WRITE, READ, PERR.
  - IDLE -> SEL when csbar==0.
  - SEL: on an ALE falling edge, latch addr={abus,dbus_in} -> ADDR.
  - ADDR:
    - wbar falling edge -> WRITE.
    - rbar falling edge -> READ.
    - A new ALE falling edge re-latches the address.
    - Levels present at ADDR entry are ignored; only edges count, so Rbar/Wbar idling low is harmless.
  - WRITE:
    - On the wbar rising edge, sample dbus_in and commit if the address is valid -> ADDR.
    - wr_pulse and the register update occur in the same cycle: 1 clock after the synchronised rising edge.
  - READ:
    - dbus_oe=1 and dbus_out=the addressed register while rbar==0.
    - An invalid address reads 8'h00.
    - rbar rising -> ADDR, and dbus_oe drops the same cycle.
  - Both rbar==0 and wbar==0 in WRITE/READ/ADDR -> PERR:
    - Set proto_err, no commit, dbus_oe=0.
    - Exit to ADDR once both strobes are high.
- csbar rising from any non-IDLE state -> IDLE.
  - A pending write without a wbar rising edge is dropped.
  - If the wbar rise and the csbar rise arrive in the same synchronised cycle, the write commits.
- Address valid iff (addr - BASE_ADDR) < 10, using unsigned 16-bit arithmetic with wrap-around. A write to an invalid address gives no pulse and no change.
- Range check:
  - hour > 23 or minute > 59: the write is rejected, range_err is set, and wr_pulse still fires with wr_index.
  - B0..B6 and operand accept all 8-bit values.
- err_clr:
  - Clears both sticky flags.
  - A new error in the same cycle as err_clr wins: the flag stays set.

Optional Feature:
- MCU_READBACK_EN defined: READ state drives dbus_oe/dbus_out as described above.
- Not defined: READ is still traversed for protocol tracking, but dbus_oe stays 0 and dbus_out stays 8'h00.

Decomposition:
- Shared package th99_pkg:
  - Register index constants: IDX_B0..IDX_B6, IDX_OPERAND=7, IDX_HOUR=8, IDX_MINUTE=9.
  - NUM_REGS=10, HOUR_MAX=23, MINUTE_MAX=59.
  - FSM state enum.
- One sub-module: bus_sync, a parameterised N-stage synchroniser with reset value, instantiated per input.

Test Plan:
- Write B0..B6=10, operand=8'hFF, hour=23, minute=33 with the standard CS/ALE/W sequence:
  - b_regs=56'h0A0A0A0A0A0A0A, operand=FF, hour=23, minute=33.
  - 10 wr_pulses with wr_index 0..9.
- Write hour=24, then minute=60:
  - hour and minute unchanged; range_err=1 and stays set.
  - err_clr -> range_err=0.
- Write to address 16'h0100 (valid iff (16'h0100 - BASE_ADDR) < 10; invalid at default BASE_ADDR), data 8'h55: no wr_pulse, all registers unchanged.
- Raise csbar while wbar is still low after a write started, then start a new transaction: no commit for the aborted write; the next transaction works normally.
- With MCU_READBACK_EN, read minute after writing 33:
  - dbus_oe=1 and dbus_out=8'd33 only while rbar is low.
  - Without the macro: dbus_oe stays 0.
- Drive rbar and wbar low together mid-transaction: proto_err=1, no register change. Assert reset=0 mid-write: all outputs 0, FSM in IDLE.

Source files
------------

// File: rtl/th99_pkg.sv
// Shared definitions for the TH99CHLS configuration bus: register map,
// value limits, bus FSM states and the write request payload.
package th99_pkg;

    localparam int unsigned NUM_REGS = 10;
    localparam int unsigned IDX_W    = 4;
    localparam int unsigned DATA_W   = 8;
    localparam int unsigned ADDR_W   = 16;

    localparam logic [IDX_W-1:0] IDX_B0      = 4'd0;
    localparam logic [IDX_W-1:0] IDX_B1      = 4'd1;
    localparam logic [IDX_W-1:0] IDX_B2      = 4'd2;
    localparam logic [IDX_W-1:0] IDX_B3      = 4'd3;
    localparam logic [IDX_W-1:0] IDX_B4      = 4'd4;
    localparam logic [IDX_W-1:0] IDX_B5      = 4'd5;
    localparam logic [IDX_W-1:0] IDX_B6      = 4'd6;
    localparam logic [IDX_W-1:0] IDX_OPERAND = 4'd7;
    localparam logic [IDX_W-1:0] IDX_HOUR    = 4'd8;
    localparam logic [IDX_W-1:0] IDX_MINUTE  = 4'd9;

    localparam logic [DATA_W-1:0] HOUR_MAX   = 8'd23;
    localparam logic [DATA_W-1:0] MINUTE_MAX = 8'd59;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SEL   = 3'd1,
        ADDR  = 3'd2,
        WRITE = 3'd3,
        READ  = 3'd4,
        PERR  = 3'd5
    } bus_state_t;

    typedef struct packed {
        logic [IDX_W-1:0]  idx;
        logic [DATA_W-1:0] data;
    } wr_req_t;

    // Time-of-day registers reject out-of-range values; everything else takes any byte.
    function automatic logic value_in_range(input logic [IDX_W-1:0] idx,
                                            input logic [DATA_W-1:0] data);
        case (idx)
            IDX_HOUR:   return data <= HOUR_MAX;
            IDX_MINUTE: return data <= MINUTE_MAX;
            default:    return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/bus_sync.sv
// N-stage synchroniser with a configurable reset value; stage count is
// clamped to at least two flops.
module bus_sync #(
    parameter int unsigned W      = 1,
    parameter int unsigned STAGES = 2,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [W-1:0] raw,
    output logic [W-1:0] synced
);

    localparam int unsigned N = (STAGES < 2) ? 2 : STAGES;

    logic [N-1:0][W-1:0] pipe;

    always_ff @(posedge clock) begin
        if (!reset) begin
            pipe <= {N{RST_VAL}};
        end else begin
            pipe <= {pipe[N-2:0], raw};
        end
    end

    assign synced = pipe[N-1];

endmodule

// File: rtl/mcu_bus_if.sv
// Multiplexed MCU bus decoder and configuration register file for the TH99CHLS core.
// Define MCU_READBACK_EN to let the READ state drive dbus_oe/dbus_out.
module mcu_bus_if
    import th99_pkg::*;
#(
    parameter int unsigned  SYNC_STAGES = 2,
    parameter logic [15:0]  BASE_ADDR   = 16'h0000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [7:0]        abus,
    input  logic [7:0]        dbus_in,
    output logic [7:0]        dbus_out,
    output logic              dbus_oe,
    input  logic              csbar,
    input  logic              ale,
    input  logic              rbar,
    input  logic              wbar,
    output logic [55:0]       b_regs,
    output logic [7:0]        operand,
    output logic [7:0]        hour,
    output logic [7:0]        minute,
    output logic              wr_pulse,
    output logic [IDX_W-1:0]  wr_index,
    output logic              range_err,
    output logic              proto_err,
    input  logic              err_clr
);

    logic [7:0] abus_s, dbus_s;
    logic       cs_s, ale_s, rb_s, wb_s;
    logic       cs_q, ale_q, rb_q, wb_q;
    logic       cs_rise, ale_fall, rb_fall, rb_rise, wb_fall, wb_rise, both_low;

    bus_state_t state, state_nxt;
    logic       latch_c, commit_c, proto_set_c, range_set_c;

    logic [ADDR_W-1:0] addr, addr_off;
    logic              addr_ok;
    wr_req_t           req;
    logic [DATA_W-1:0] regs [NUM_REGS];

    bus_sync #(.W(8), .STAGES(SYNC_STAGES), .RST_VAL(8'h00)) u_sync_abus (
        .clock(clock), .reset(reset), .raw(abus), .synced(abus_s));
    bus_sync #(.W(8), .STAGES(SYNC_STAGES), .RST_VAL(8'h00)) u_sync_dbus (
        .clock(clock), .reset(reset), .raw(dbus_in), .synced(dbus_s));
    bus_sync #(.W(1), .STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .clock(clock), .reset(reset), .raw(csbar), .synced(cs_s));
    bus_sync #(.W(1), .STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_ale (
        .clock(clock), .reset(reset), .raw(ale), .synced(ale_s));
    bus_sync #(.W(1), .STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_rb (
        .clock(clock), .reset(reset), .raw(rbar), .synced(rb_s));
    bus_sync #(.W(1), .STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_wb (
        .clock(clock), .reset(reset), .raw(wbar), .synced(wb_s));

    // Previous synchronised strobe levels for edge detection
    always_ff @(posedge clock) begin
        if (!reset) begin
            cs_q  <= 1'b1;
            ale_q <= 1'b0;
            rb_q  <= 1'b1;
            wb_q  <= 1'b1;
        end else begin
            cs_q  <= cs_s;
            ale_q <= ale_s;
            rb_q  <= rb_s;
            wb_q  <= wb_s;
        end
    end

    assign cs_rise  = !cs_q && cs_s;
    assign ale_fall = ale_q && !ale_s;
    assign rb_fall  = rb_q && !rb_s;
    assign rb_rise  = !rb_q && rb_s;
    assign wb_fall  = wb_q && !wb_s;
    assign wb_rise  = !wb_q && wb_s;
    assign both_low = !rb_s && !wb_s;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (!cs_s) state_nxt = SEL;
            SEL: begin
                if (cs_rise)       state_nxt = IDLE;
                else if (ale_fall) state_nxt = ADDR;
            end
            ADDR: begin
                if (both_low)     state_nxt = PERR;
                else if (cs_rise) state_nxt = IDLE;
                else if (wb_fall) state_nxt = WRITE;
                else if (rb_fall) state_nxt = READ;
            end
            // A wbar rise coinciding with csbar rise still commits
            WRITE: begin
                if (both_low)     state_nxt = PERR;
                else if (wb_rise) state_nxt = cs_rise ? IDLE : ADDR;
                else if (cs_rise) state_nxt = IDLE;
            end
            READ: begin
                if (both_low)     state_nxt = PERR;
                else if (cs_rise) state_nxt = IDLE;
                else if (rb_rise) state_nxt = ADDR;
            end
            PERR: begin
                if (cs_rise)          state_nxt = IDLE;
                else if (rb_s && wb_s) state_nxt = ADDR;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        latch_c     = 1'b0;
        commit_c    = 1'b0;
        proto_set_c = 1'b0;
        unique case (state)
            SEL:   latch_c = !cs_rise && ale_fall;
            ADDR: begin
                proto_set_c = both_low;
                latch_c     = !both_low && !cs_rise && !wb_fall && !rb_fall && ale_fall;
            end
            WRITE: begin
                proto_set_c = both_low;
                commit_c    = !both_low && wb_rise;
            end
            READ:  proto_set_c = both_low;
            default: ;
        endcase
    end

    // Offset wraps mod 2^16, so addresses below BASE_ADDR land out of range
    assign addr_off    = addr - BASE_ADDR;
    assign addr_ok     = addr_off < ADDR_W'(NUM_REGS);
    assign req.idx     = addr_off[IDX_W-1:0];
    assign req.data    = dbus_s;
    assign range_set_c = commit_c && addr_ok && !value_in_range(req.idx, req.data);

    always_ff @(posedge clock) begin
        if (!reset) begin
            addr      <= '0;
            regs      <= '{default: '0};
            wr_pulse  <= 1'b0;
            wr_index  <= '0;
            range_err <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            wr_pulse <= 1'b0;
            if (latch_c) begin
                addr <= {abus_s, dbus_s};
            end
            if (commit_c && addr_ok) begin
                wr_pulse <= 1'b1;
                wr_index <= req.idx;
                if (value_in_range(req.idx, req.data)) begin
                    regs[req.idx] <= req.data;
                end
            end
            range_err <= range_set_c || (range_err && !err_clr);
            proto_err <= proto_set_c || (proto_err && !err_clr);
        end
    end

`ifdef MCU_READBACK_EN
    logic              oe_c;
    logic [DATA_W-1:0] rd_data;

    assign oe_c    = (state == READ) && !rb_s && wb_s && !cs_rise;
    assign rd_data = addr_ok ? regs[req.idx] : 8'h00;

    always_ff @(posedge clock) begin
        if (!reset) begin
            dbus_oe  <= 1'b0;
            dbus_out <= 8'h00;
        end else begin
            dbus_oe  <= oe_c;
            dbus_out <= oe_c ? rd_data : 8'h00;
        end
    end
`else
    assign dbus_oe  = 1'b0;
    assign dbus_out = 8'h00;
`endif

    assign b_regs  = {regs[IDX_B6], regs[IDX_B5], regs[IDX_B4], regs[IDX_B3],
                      regs[IDX_B2], regs[IDX_B1], regs[IDX_B0]};
    assign operand = regs[IDX_OPERAND];
    assign hour    = regs[IDX_HOUR];
    assign minute  = regs[IDX_MINUTE];

endmodule

// File: tb/tb_mcu_bus_if.sv
// Directed self-checking bench for mcu_bus_if: register writes, range and
// address rejection, aborted writes, protocol errors, readback and reset.
module tb_mcu_bus_if;
    import th99_pkg::*;

    logic        clock   = 1'b0;
    logic        reset   = 1'b0;
    logic [7:0]  abus    = 8'h00;
    logic [7:0]  dbus_in = 8'h00;
    logic [7:0]  dbus_out;
    logic        dbus_oe;
    logic        csbar   = 1'b1;
    logic        ale     = 1'b0;
    logic        rbar    = 1'b1;
    logic        wbar    = 1'b1;
    logic [55:0] b_regs;
    logic [7:0]  operand, hour, minute;
    logic        wr_pulse;
    logic [3:0]  wr_index;
    logic        range_err, proto_err;
    logic        err_clr = 1'b0;

    int checks = 0;
    int errors = 0;
    int pulse_cnt = 0;
    logic [3:0] idx_q [$];
    logic       exp_oe;
    logic [7:0] exp_out;

    mcu_bus_if dut (
        .clock(clock), .reset(reset), .abus(abus), .dbus_in(dbus_in),
        .dbus_out(dbus_out), .dbus_oe(dbus_oe), .csbar(csbar), .ale(ale),
        .rbar(rbar), .wbar(wbar), .b_regs(b_regs), .operand(operand),
        .hour(hour), .minute(minute), .wr_pulse(wr_pulse), .wr_index(wr_index),
        .range_err(range_err), .proto_err(proto_err), .err_clr(err_clr)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (wr_pulse) begin
            pulse_cnt++;
            idx_q.push_back(wr_index);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic start_addr(input logic [15:0] a);
        csbar = 1'b0;
        cyc(4);
        abus = a[15:8];
        dbus_in = a[7:0];
        ale = 1'b1;
        cyc(4);
        ale = 1'b0;
        cyc(4);
    endtask

    task automatic end_cycle();
        csbar = 1'b1;
        cyc(4);
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
        start_addr(a);
        dbus_in = d;
        wbar = 1'b0;
        cyc(4);
        wbar = 1'b1;
        cyc(4);
        end_cycle();
    endtask

    initial begin
        cyc(3);
        check("rst_b_regs", 64'(b_regs), 64'h0);
        check("rst_outs", 64'({operand, hour, minute, wr_index}), 64'h0);
        check("rst_flags", 64'({wr_pulse, range_err, proto_err, dbus_oe, dbus_out}), 64'h0);
        reset = 1'b1;
        cyc(2);

        for (int i = 0; i < 7; i++) bus_write(16'(i), 8'd10);
        bus_write(16'd7, 8'hFF);
        bus_write(16'd8, 8'd23);
        bus_write(16'd9, 8'd33);
        check("b_regs_all", 64'(b_regs), 64'h000A0A0A0A0A0A0A);
        check("operand", 64'(operand), 64'hFF);
        check("hour", 64'(hour), 64'd23);
        check("minute", 64'(minute), 64'd33);
        check("pulse_cnt10", 64'(pulse_cnt), 64'd10);
        for (int i = 0; i < 10; i++) begin
            if (i < idx_q.size()) check($sformatf("wr_idx%0d", i), 64'(idx_q[i]), 64'(i));
            else check($sformatf("wr_idx%0d_missing", i), 64'(idx_q.size()), 64'(i + 1));
        end

`ifdef MCU_READBACK_EN
        exp_oe = 1'b1; exp_out = 8'd33;
`else
        exp_oe = 1'b0; exp_out = 8'h00;
`endif
        start_addr(16'd9);
        check("rd_oe_idle", 64'(dbus_oe), 64'd0);
        rbar = 1'b0;
        cyc(4);
        check("rd_oe_low", 64'(dbus_oe), 64'(exp_oe));
        check("rd_data", 64'(dbus_out), 64'(exp_out));
        rbar = 1'b1;
        cyc(4);
        check("rd_oe_after", 64'(dbus_oe), 64'd0);
        end_cycle();

        bus_write(16'd8, 8'd24);
        check("hour_rej", 64'(hour), 64'd23);
        check("range_err_h", 64'(range_err), 64'd1);
        check("pulse_rej", 64'(pulse_cnt), 64'd11);
        check("rej_idx", 64'(idx_q[idx_q.size()-1]), 64'd8);
        bus_write(16'd9, 8'd60);
        check("minute_rej", 64'(minute), 64'd33);
        check("range_err_m", 64'(range_err), 64'd1);
        err_clr = 1'b1;
        cyc(1);
        err_clr = 1'b0;
        cyc(1);
        check("range_clr", 64'(range_err), 64'd0);

        bus_write(16'h0100, 8'h55);
        check("inv_pulse", 64'(pulse_cnt), 64'd12);
        check("inv_b_regs", 64'(b_regs), 64'h000A0A0A0A0A0A0A);
        check("inv_cfg", 64'({operand, hour, minute}), 64'hFF1721);

        start_addr(16'd0);
        dbus_in = 8'h77;
        wbar = 1'b0;
        cyc(4);
        csbar = 1'b1;
        cyc(4);
        wbar = 1'b1;
        cyc(4);
        check("abort_pulse", 64'(pulse_cnt), 64'd12);
        check("abort_b0", 64'(b_regs), 64'h000A0A0A0A0A0A0A);
        bus_write(16'd1, 8'h42);
        check("post_abort", 64'(b_regs), 64'h000A0A0A0A0A420A);
        check("post_abort_pulse", 64'(pulse_cnt), 64'd13);

        start_addr(16'd7);
        dbus_in = 8'h12;
        rbar = 1'b0;
        wbar = 1'b0;
        cyc(4);
        check("proto_set", 64'(proto_err), 64'd1);
        check("proto_oe", 64'(dbus_oe), 64'd0);
        rbar = 1'b1;
        wbar = 1'b1;
        cyc(4);
        end_cycle();
        check("proto_operand", 64'(operand), 64'hFF);
        check("proto_pulse", 64'(pulse_cnt), 64'd13);
        err_clr = 1'b1;
        cyc(1);
        err_clr = 1'b0;
        cyc(1);
        check("proto_clr", 64'(proto_err), 64'd0);

        start_addr(16'd0);
        dbus_in = 8'h99;
        wbar = 1'b0;
        cyc(4);
        reset = 1'b0;
        cyc(2);
        check("mid_rst_b", 64'(b_regs), 64'h0);
        check("mid_rst_cfg", 64'({operand, hour, minute, wr_index}), 64'h0);
        check("mid_rst_flags", 64'({wr_pulse, range_err, proto_err, dbus_oe, dbus_out}), 64'h0);
        check("mid_rst_state", 64'(dut.state), 64'(IDLE));
        wbar = 1'b1;
        csbar = 1'b1;
        cyc(4);
        reset = 1'b1;
        cyc(6);
        check("post_rst_b", 64'(b_regs), 64'h0);
        check("post_rst_pulse", 64'(pulse_cnt), 64'd13);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
